// File: rtl/evrisim_sonuc_yazici.sv
// evrisim_sonuc_yazici
// Collects the filtered pixel stream from the 3x3 convolution unit and packs
// four pixels into one 32-bit little-endian word. Words go into a small FIFO,
// because the source has no back-pressure, and are then written to result
// memory over a valid/ready port. A one-cycle frame-done pulse follows the
// acceptance of the last word of the frame.

module evrisim_sonuc_yazici #(
  parameter int          GENISLIK      = 320,
  parameter int          YUKSEKLIK     = 240,
  parameter logic [31:0] TABAN_ADRES   = 32'h0000_0000,
  parameter int          FIFO_DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        baslat_i,
  input  logic        veri_etkin_i,
  input  logic [7:0]  veri_i,
  output logic        bellek_gecerli_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  input  logic        bellek_hazir_i,
  output logic        mesgul_o,
  output logic        kare_bitti_o,
  output logic        tasma_o
);

  // FIFO pointer and occupancy widths; occupancy needs one extra bit for "full"
  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int SW = AW + 1;

  localparam logic [16:0]   SON_PIKSEL = 17'(GENISLIK * YUKSEKLIK - 1);
  localparam logic [SW-1:0] DOLU       = SW'(FIFO_DERINLIK);
  localparam logic [SW-1:0] SAYI_BIR   = SW'(1);
  localparam logic [AW-1:0] PTR_BIR    = AW'(1);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    TOPLA  = 2'd1,
    BOSALT = 2'd2,
    BITTI  = 2'd3
  } durum_e;

  // Frame control state
  durum_e        durum_q,   durum_d;
  logic [16:0]   piksel_q,  piksel_d;
  logic [31:0]   paket_q,   paket_d;
  logic [14:0]   kelime_q,  kelime_d;
  logic          tasma_q,   tasma_d;
  logic          mesgul_q,  mesgul_d;
  logic          kare_bitti_q, kare_bitti_d;

  // Word FIFO storage and bookkeeping
  logic [31:0]   adr_mem_q  [FIFO_DERINLIK];
  logic [31:0]   veri_mem_q [FIFO_DERINLIK];
  logic [AW-1:0] yaz_ptr_q, yaz_ptr_d;
  logic [AW-1:0] oku_ptr_q, oku_ptr_d;
  logic [SW-1:0] sayi_q,    sayi_d;

  // Handshake between the packer and the FIFO
  logic          push_s;
  logic          yaz_s;
  logic          pop_s;
  logic          bos_s;
  logic          dolu_s;
  logic          tasma_olay_s;
  logic [31:0]   yeni_adres_s;
  logic [31:0]   yeni_veri_s;

  // FIFO status, accepted pushes/pops and overflow detection
  always_comb begin
    bos_s        = (sayi_q == {SW{1'b0}});
    dolu_s       = (sayi_q == DOLU);
    pop_s        = (!bos_s) && bellek_hazir_i;
    // A full FIFO still takes a word when the head leaves on the same edge
    yaz_s        = push_s && ((!dolu_s) || pop_s);
    tasma_olay_s = push_s && dolu_s && (!pop_s);
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    if (yaz_s) begin
      yaz_ptr_d = yaz_ptr_q + PTR_BIR;
    end else begin
      yaz_ptr_d = yaz_ptr_q;
    end
    if (pop_s) begin
      oku_ptr_d = oku_ptr_q + PTR_BIR;
    end else begin
      oku_ptr_d = oku_ptr_q;
    end
    case ({yaz_s, pop_s})
      2'b10:   sayi_d = sayi_q + SAYI_BIR;
      2'b01:   sayi_d = sayi_q - SAYI_BIR;
      default: sayi_d = sayi_q;
    endcase
  end

  // Packing, word addressing and frame state next-state
  always_comb begin
    durum_d      = durum_q;
    piksel_d     = piksel_q;
    paket_d      = paket_q;
    kelime_d     = kelime_q;
    tasma_d      = tasma_q;
    push_s       = 1'b0;
    // The 4th byte bypasses the packing register straight into the word
    yeni_veri_s  = {veri_i, paket_q[23:0]};
    // Word index is zero-extended and scaled by 4; the sum wraps at 32 bits
    yeni_adres_s = TABAN_ADRES + {15'd0, kelime_q, 2'b00};

    case (durum_q)
      BOSTA: begin
        if (baslat_i) begin
          durum_d  = TOPLA;
          piksel_d = 17'd0;
          paket_d  = 32'd0;
          kelime_d = 15'd0;
          tasma_d  = 1'b0;
        end else begin
          durum_d  = BOSTA;
        end
      end
      TOPLA: begin
        if (veri_etkin_i) begin
          piksel_d = piksel_q + 17'd1;
          case (piksel_q[1:0])
            2'd0:    paket_d[7:0]   = veri_i;
            2'd1:    paket_d[15:8]  = veri_i;
            2'd2:    paket_d[23:16] = veri_i;
            2'd3: begin
              push_s   = 1'b1;
              paket_d  = 32'd0;
              kelime_d = kelime_q + 15'd1;
            end
            default: paket_d = paket_q;
          endcase
          if (piksel_q == SON_PIKSEL) begin
            durum_d = BOSALT;
          end else begin
            durum_d = TOPLA;
          end
        end else begin
          durum_d = TOPLA;
        end
      end
      BOSALT: begin
        if (bos_s) begin
          durum_d = BITTI;
        end else begin
          durum_d = BOSALT;
        end
      end
      BITTI: begin
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase

    // Overflow is sticky until the next accepted start
    if (tasma_olay_s) begin
      tasma_d = 1'b1;
    end else begin
      tasma_d = tasma_d;
    end

    mesgul_d     = (durum_d != BOSTA);
    kare_bitti_d = (durum_d == BITTI);
  end

  // Frame state machine with its registered status outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q      <= BOSTA;
      piksel_q     <= 17'd0;
      paket_q      <= 32'd0;
      kelime_q     <= 15'd0;
      tasma_q      <= 1'b0;
      mesgul_q     <= 1'b0;
      kare_bitti_q <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      piksel_q     <= piksel_d;
      paket_q      <= paket_d;
      kelime_q     <= kelime_d;
      tasma_q      <= tasma_d;
      mesgul_q     <= mesgul_d;
      kare_bitti_q <= kare_bitti_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr_q <= {AW{1'b0}};
      oku_ptr_q <= {AW{1'b0}};
      sayi_q    <= {SW{1'b0}};
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
    end
  end

  // FIFO storage; cleared on reset so the memory port reads zero
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DERINLIK; i++) begin
        adr_mem_q[i]  <= 32'd0;
        veri_mem_q[i] <= 32'd0;
      end
    end else if (yaz_s) begin
      adr_mem_q[yaz_ptr_q]  <= yeni_adres_s;
      veri_mem_q[yaz_ptr_q] <= yeni_veri_s;
    end
  end

  // Head of the FIFO drives the memory port; it only moves on a transfer
  assign bellek_gecerli_o = !bos_s;
  assign bellek_adres_o   = adr_mem_q[oku_ptr_q];
  assign bellek_veri_o    = veri_mem_q[oku_ptr_q];
  assign mesgul_o         = mesgul_q;
  assign kare_bitti_o     = kare_bitti_q;
  assign tasma_o          = tasma_q;

endmodule

// File: tb/tb_evrisim_sonuc_yazici.sv
// Directed bench for evrisim_sonuc_yazici with an 8x4 frame (32 pixels,
// 8 words) so the 4-deep FIFO can be driven into overflow.

module tb_evrisim_sonuc_yazici;

  localparam int          G     = 8;
  localparam int          Y     = 4;
  localparam logic [31:0] TABAN = 32'h0000_1000;
  localparam int          D     = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        baslat_i;
  logic        veri_etkin_i;
  logic [7:0]  veri_i;
  logic        bellek_gecerli_o;
  logic [31:0] bellek_adres_o;
  logic [31:0] bellek_veri_o;
  logic        bellek_hazir_i;
  logic        mesgul_o;
  logic        kare_bitti_o;
  logic        tasma_o;

  evrisim_sonuc_yazici #(
    .GENISLIK(G), .YUKSEKLIK(Y), .TABAN_ADRES(TABAN), .FIFO_DERINLIK(D)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .baslat_i(baslat_i),
    .veri_etkin_i(veri_etkin_i), .veri_i(veri_i),
    .bellek_gecerli_o(bellek_gecerli_o), .bellek_adres_o(bellek_adres_o),
    .bellek_veri_o(bellek_veri_o), .bellek_hazir_i(bellek_hazir_i),
    .mesgul_o(mesgul_o), .kare_bitti_o(kare_bitti_o), .tasma_o(tasma_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory-side monitor: record every transfer and every frame-done cycle
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  int          obs_cyc[$];
  int          kb_sayisi = 0;
  int          kb_cyc = 0;
  always @(negedge clk_i) begin
    if (rstn_i && bellek_gecerli_o && bellek_hazir_i) begin
      obs_adr.push_back(bellek_adres_o);
      obs_dat.push_back(bellek_veri_o);
      obs_cyc.push_back(cyc + 1);
    end
    if (kare_bitti_o) begin
      kb_sayisi <= kb_sayisi + 1;
      kb_cyc    <= cyc;
    end
  end

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim(input logic e, input logic [7:0] v);
    veri_etkin_i = e;
    veri_i       = v;
    @(posedge clk_i); #1;
    veri_etkin_i = 1'b0;
  endtask

  task automatic baslat();
    baslat_i = 1'b1;
    @(posedge clk_i); #1;
    baslat_i = 1'b0;
  endtask

  task automatic kare_bekle();
    int n;
    int k0;
    n  = 0;
    k0 = kb_sayisi;
    while (kb_sayisi == k0 && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  // Expected word i of a frame whose pixels count up from v0
  task automatic yazim_kontrol(input string etk, input int bas, input int n,
                               input logic [7:0] v0);
    kontrol({etk, "_adet"}, 32'(obs_adr.size() - bas), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (bas + i < obs_adr.size()) begin
        kontrol($sformatf("%s_adr%0d", etk, i), obs_adr[bas + i], TABAN + 32'(4 * i));
        kontrol($sformatf("%s_dat%0d", etk, i), obs_dat[bas + i],
                {v0 + 8'(4 * i + 3), v0 + 8'(4 * i + 2), v0 + 8'(4 * i + 1), v0 + 8'(4 * i)});
      end
    end
  endtask

  task automatic cikis_sifir(input string etk);
    kontrol({etk, "_gecerli"}, 32'(bellek_gecerli_o), 32'd0);
    kontrol({etk, "_adres"},   bellek_adres_o,        32'd0);
    kontrol({etk, "_veri"},    bellek_veri_o,         32'd0);
    kontrol({etk, "_mesgul"},  32'(mesgul_o),         32'd0);
    kontrol({etk, "_kb"},      32'(kare_bitti_o),     32'd0);
    kontrol({etk, "_tasma"},   32'(tasma_o),          32'd0);
  endtask

  initial begin
    int bas;
    int k0;
    int son;
    int n4;

    rstn_i = 1'b0; baslat_i = 1'b0; veri_etkin_i = 1'b0; veri_i = 8'd0;
    bellek_hazir_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    cikis_sifir("reset");
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Ramp frame, memory always ready
    bellek_hazir_i = 1'b1;
    bas = obs_adr.size(); k0 = kb_sayisi; n4 = 0;
    baslat();
    kontrol("rampa_mesgul", 32'(mesgul_o), 32'd1);
    for (int i = 0; i < 32; i++) begin
      adim(1'b1, 8'(i));
      if (i == 3) begin
        n4 = cyc;
        kontrol("rampa_ilk_gecerli", 32'(bellek_gecerli_o), 32'd1);
        kontrol("rampa_ilk_adres", bellek_adres_o, 32'h0000_1000);
        kontrol("rampa_ilk_veri", bellek_veri_o, 32'h0302_0100);
      end
    end
    son = cyc;
    kare_bekle();
    yazim_kontrol("rampa", bas, 8, 8'h00);
    if (obs_cyc.size() > bas) kontrol("rampa_ilk_gecikme", 32'(obs_cyc[bas] - n4), 32'd1);
    kontrol("rampa_kb_adet", 32'(kb_sayisi - k0), 32'd1);
    kontrol("rampa_kb_zaman", 32'(kb_cyc - son), 32'd2);
    kontrol("rampa_tasma", 32'(tasma_o), 32'd0);
    kontrol("rampa_mesgul_son", 32'(mesgul_o), 32'd0);

    // Back-pressure: memory stalled while the first 12 pixels arrive
    bellek_hazir_i = 1'b0;
    bas = obs_adr.size(); k0 = kb_sayisi;
    baslat();
    for (int i = 0; i < 32; i++) begin
      if (i == 12) bellek_hazir_i = 1'b1;
      adim(1'b1, 8'(i));
      if (i == 7 || i == 11) begin
        kontrol($sformatf("gb_gecerli_%0d", i), 32'(bellek_gecerli_o), 32'd1);
        kontrol($sformatf("gb_adres_%0d", i), bellek_adres_o, 32'h0000_1000);
        kontrol($sformatf("gb_veri_%0d", i), bellek_veri_o, 32'h0302_0100);
      end
      if (i == 11) kontrol("gb_yazim_yok", 32'(obs_adr.size() - bas), 32'd0);
    end
    kare_bekle();
    yazim_kontrol("gb", bas, 8, 8'h00);
    kontrol("gb_kb_adet", 32'(kb_sayisi - k0), 32'd1);
    kontrol("gb_kb_sonra", 32'(kb_cyc > obs_cyc[$]), 32'd1);
    kontrol("gb_tasma", 32'(tasma_o), 32'd0);

    // Overflow: memory stalled for the whole frame
    bellek_hazir_i = 1'b0;
    bas = obs_adr.size(); k0 = kb_sayisi;
    baslat();
    for (int i = 0; i < 32; i++) begin
      adim(1'b1, 8'h20 + 8'(i));
      if (i == 15) kontrol("tasma_dort_kelime", 32'(tasma_o), 32'd0);
      if (i == 19) kontrol("tasma_bes_kelime", 32'(tasma_o), 32'd1);
    end
    repeat (5) adim(1'b0, 8'd0);
    kontrol("tasma_bosalt_mesgul", 32'(mesgul_o), 32'd1);
    kontrol("tasma_kb_erken", 32'(kb_sayisi - k0), 32'd0);
    bellek_hazir_i = 1'b1;
    kare_bekle();
    yazim_kontrol("tasma", bas, 4, 8'h20);
    kontrol("tasma_kb_adet", 32'(kb_sayisi - k0), 32'd1);
    kontrol("tasma_yapiskan", 32'(tasma_o), 32'd1);

    // Idle filtering: pixels before start, on the start edge and after the frame
    bas = obs_adr.size(); k0 = kb_sayisi;
    adim(1'b1, 8'hAA); adim(1'b0, 8'h00); adim(1'b1, 8'hBB); adim(1'b1, 8'hCC);
    kontrol("filtre_bosta_yazim", 32'(obs_adr.size() - bas), 32'd0);
    baslat_i = 1'b1; veri_etkin_i = 1'b1; veri_i = 8'hEE;
    @(posedge clk_i); #1;
    baslat_i = 1'b0; veri_etkin_i = 1'b0;
    kontrol("filtre_tasma_temiz", 32'(tasma_o), 32'd0);
    for (int i = 0; i < 32; i++) adim(1'b1, 8'h40 + 8'(i));
    kare_bekle();
    repeat (3) adim(1'b1, 8'h99);
    repeat (4) adim(1'b0, 8'h00);
    yazim_kontrol("filtre", bas, 8, 8'h40);
    kontrol("filtre_kb_adet", 32'(kb_sayisi - k0), 32'd1);

    // Gapped input: one pixel every third cycle
    bas = obs_adr.size(); k0 = kb_sayisi;
    baslat();
    for (int i = 0; i < 32; i++) begin
      adim(1'b1, 8'(i));
      if (i < 31) begin adim(1'b0, 8'h55); adim(1'b0, 8'h66); end
    end
    son = cyc;
    kare_bekle();
    yazim_kontrol("aralik", bas, 8, 8'h00);
    kontrol("aralik_kb_adet", 32'(kb_sayisi - k0), 32'd1);
    kontrol("aralik_kb_zaman", 32'(kb_cyc - son), 32'd2);

    // Reset mid-frame with a word pending, then a clean ramp frame
    bellek_hazir_i = 1'b0;
    k0 = kb_sayisi;
    baslat();
    for (int i = 0; i < 6; i++) adim(1'b1, 8'h60 + 8'(i));
    kontrol("rst_once_gecerli", 32'(bellek_gecerli_o), 32'd1);
    kontrol("rst_once_mesgul", 32'(mesgul_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1 cikis_sifir("rst_asenkron");
    @(posedge clk_i); #1;
    rstn_i = 1'b1; bellek_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    bas = obs_adr.size();
    baslat();
    for (int i = 0; i < 32; i++) adim(1'b1, 8'(i));
    kare_bekle();
    yazim_kontrol("rst_sonra", bas, 8, 8'h00);
    kontrol("rst_kb_adet", 32'(kb_sayisi - k0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
